// File: rtl/spi_cmd_receiver_if.sv
// Command FIFO write port between the SPI receiver and the command FIFO.
// The receiver is the master: it drives the word and strobes, the FIFO reports full.
interface spi_cmd_receiver_if #(
  parameter int WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] command_wrdata;
  logic                  command_push;
  logic                  command_first;
  logic                  command_full;

  modport master (
    output command_wrdata,
    output command_push,
    output command_first,
    input  command_full
  );

  modport slave (
    input  command_wrdata,
    input  command_push,
    input  command_first,
    output command_full
  );
endinterface

// File: rtl/spi_cmd_receiver.sv
// SPI slave front end: synchronises the SPI pins into clk, deserialises
// LANES bits per rising spi_clk edge and pushes WORD_WIDTH words to the FIFO.
module spi_cmd_receiver #(
  parameter int WORD_WIDTH     = 8,
  parameter int LANES          = 1,
  parameter bit CS_ACTIVE_HIGH = 1'b1,
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_clk,
  input  logic                  spi_cs,
  input  logic [LANES-1:0]      spi_data,
  spi_cmd_receiver_if.master    cmd,
  output logic                  frame_abort,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic [CNT_WIDTH-1:0]  abort_count
);

  localparam int BCW = $clog2(WORD_WIDTH + 1);
  localparam int LS  = SYNC_STAGES - 1;
  localparam logic [BCW-1:0] STEP = BCW'(LANES);
  localparam logic [BCW-1:0] LAST = BCW'(WORD_WIDTH - LANES);

  typedef enum logic {
    IDLE,
    SELECTED
  } state_t;

  // CS is normalised to "selected" before the synchroniser,
  // so a reset chain of zeros always means "not selected".
  logic cs_pin_act;

  assign cs_pin_act = CS_ACTIVE_HIGH ? spi_cs : ~spi_cs;

  logic [SYNC_STAGES-1:0]            clk_q;
  logic [SYNC_STAGES-1:0]            cs_q;
  logic [SYNC_STAGES-1:0][LANES-1:0] dat_q;
  logic                              clk_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_q    <= '0;
      cs_q     <= '0;
      dat_q    <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_q    <= {clk_q[LS-1:0], spi_clk};
      cs_q     <= {cs_q[LS-1:0], cs_pin_act};
      dat_q    <= {dat_q[LS-1:0], spi_data};
      clk_prev <= clk_q[LS];
    end
  end

  logic             cs_s;
  logic             rise;
  logic [LANES-1:0] dat_s;

  assign cs_s  = cs_q[LS];
  assign dat_s = dat_q[LS];
  assign rise  = clk_q[LS] & ~clk_prev;

  state_t                state;
  logic [WORD_WIDTH-1:0] shift;
  logic [WORD_WIDTH-1:0] shift_nxt;
  logic [BCW-1:0]        bitcnt;
  logic                  first_pend;

  assign shift_nxt = WORD_WIDTH'({shift, dat_s});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      shift              <= '0;
      bitcnt             <= '0;
      first_pend         <= 1'b0;
      cmd.command_push   <= 1'b0;
      cmd.command_wrdata <= '0;
      cmd.command_first  <= 1'b0;
      frame_abort        <= 1'b0;
      drop_count         <= '0;
      abort_count        <= '0;
    end else begin
      cmd.command_push   <= 1'b0;
      cmd.command_wrdata <= '0;
      cmd.command_first  <= 1'b0;
      frame_abort        <= 1'b0;
      unique case (state)
        IDLE: begin
          bitcnt <= '0;
          shift  <= '0;
          if (cs_s) begin
            state      <= SELECTED;
            first_pend <= 1'b1;
          end
        end
        SELECTED: begin
          // Deselect takes priority over a coincident edge.
          if (!cs_s) begin
            state  <= IDLE;
            bitcnt <= '0;
            shift  <= '0;
            if (bitcnt != '0) begin
              frame_abort <= 1'b1;
              if (abort_count != '1)
                abort_count <= abort_count + 1'b1;
            end
          end else if (rise) begin
            if (bitcnt == LAST) begin
              bitcnt     <= '0;
              shift      <= '0;
              first_pend <= 1'b0;
              if (cmd.command_full) begin
                if (drop_count != '1)
                  drop_count <= drop_count + 1'b1;
              end else begin
                cmd.command_push   <= 1'b1;
                cmd.command_wrdata <= shift_nxt;
                cmd.command_first  <= first_pend;
              end
            end else begin
              bitcnt <= bitcnt + STEP;
              shift  <= shift_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_receiver.sv
// Bench for spi_cmd_receiver: four configurations share one SPI bus and
// are checked every cycle against a bit-stream model of the protocol.
module tb_spi_cmd_receiver;

  localparam int SYNC = 2;
  localparam int HALF = 4;
  localparam int LN [4] = '{1, 2, 4, 1};
  localparam int WW [4] = '{8, 8, 16, 8};

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_clk;
  logic       cs_a;
  logic       cs_d;
  logic [3:0] dat;
  logic       full;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_cmd_receiver_if #(.WORD_WIDTH(8))  if_a ();
  spi_cmd_receiver_if #(.WORD_WIDTH(8))  if_b ();
  spi_cmd_receiver_if #(.WORD_WIDTH(16)) if_c ();
  spi_cmd_receiver_if #(.WORD_WIDTH(8))  if_d ();

  assign if_a.command_full = full;
  assign if_b.command_full = full;
  assign if_c.command_full = full;
  assign if_d.command_full = full;

  logic       ab_v [4];
  logic [7:0] dc [4];
  logic [7:0] ac [4];

  spi_cmd_receiver #(.WORD_WIDTH(8), .LANES(1)) u_a (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs(cs_a),
    .spi_data(dat[0:0]), .cmd(if_a), .frame_abort(ab_v[0]),
    .drop_count(dc[0]), .abort_count(ac[0]));

  spi_cmd_receiver #(.WORD_WIDTH(8), .LANES(2)) u_b (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs(cs_a),
    .spi_data(dat[1:0]), .cmd(if_b), .frame_abort(ab_v[1]),
    .drop_count(dc[1]), .abort_count(ac[1]));

  spi_cmd_receiver #(.WORD_WIDTH(16), .LANES(4)) u_c (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs(cs_a),
    .spi_data(dat), .cmd(if_c), .frame_abort(ab_v[2]),
    .drop_count(dc[2]), .abort_count(ac[2]));

  spi_cmd_receiver #(.WORD_WIDTH(8), .LANES(1), .CS_ACTIVE_HIGH(1'b0)) u_d (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs(cs_d),
    .spi_data(dat[0:0]), .cmd(if_d), .frame_abort(ab_v[3]),
    .drop_count(dc[3]), .abort_count(ac[3]));

  logic        push_v  [4];
  logic        first_v [4];
  logic [15:0] data_v  [4];

  assign push_v[0]  = if_a.command_push;
  assign push_v[1]  = if_b.command_push;
  assign push_v[2]  = if_c.command_push;
  assign push_v[3]  = if_d.command_push;
  assign first_v[0] = if_a.command_first;
  assign first_v[1] = if_b.command_first;
  assign first_v[2] = if_c.command_first;
  assign first_v[3] = if_d.command_first;
  assign data_v[0]  = 16'(if_a.command_wrdata);
  assign data_v[1]  = 16'(if_b.command_wrdata);
  assign data_v[2]  = if_c.command_wrdata;
  assign data_v[3]  = 16'(if_d.command_wrdata);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: per-DUT bit stream accumulated per pin edge; a word is
  // expected SYNC+1 cycles after the pin change that completes it.
  typedef struct {
    int          dut;
    logic [15:0] data;
    bit          first;
    int          cyc;
  } exp_t;

  typedef struct {
    int dut;
    int cyc;
  } ab_t;

  exp_t pq[$];
  ab_t  aq[$];
  bit   m_sel [4];
  int   m_acc [4];
  int   m_nb [4];
  bit   m_fp [4];
  int   m_drops [4];
  int   m_aborts [4];
  logic p_clk;

  function automatic void model_reset();
    pq.delete();
    aq.delete();
    for (int i = 0; i < 4; i++) begin
      m_sel[i]    = 1'b0;
      m_acc[i]    = 0;
      m_nb[i]     = 0;
      m_fp[i]     = 1'b0;
      m_drops[i]  = 0;
      m_aborts[i] = 0;
    end
    p_clk = spi_clk;
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 4; i++) begin
      bit act;
      act = (i == 3) ? !cs_d : cs_a;
      if (act && !m_sel[i]) begin
        m_fp[i]  = 1'b1;
        m_nb[i]  = 0;
        m_acc[i] = 0;
      end else if (!act && m_sel[i]) begin
        if (m_nb[i] != 0) begin
          aq.push_back('{i, cyc + SYNC + 1});
          if (m_aborts[i] < 255) m_aborts[i]++;
        end
        m_nb[i]  = 0;
        m_acc[i] = 0;
      end else if (act && spi_clk && !p_clk) begin
        m_acc[i] = (m_acc[i] << LN[i]) | (int'(dat) & ((1 << LN[i]) - 1));
        m_nb[i]  = m_nb[i] + LN[i];
        if (m_nb[i] == WW[i]) begin
          if (full) begin
            if (m_drops[i] < 255) m_drops[i]++;
          end else begin
            pq.push_back('{i, 16'(m_acc[i]), m_fp[i], cyc + SYNC + 1});
          end
          m_fp[i]  = 1'b0;
          m_nb[i]  = 0;
          m_acc[i] = 0;
        end
      end
      m_sel[i] = act;
    end
    p_clk = spi_clk;
  endfunction

  int         obs_n [4];
  int         obs_ab [4];
  logic [15:0] obs_data [4];
  logic       obs_first [4];
  logic [8:0] a_log[$];

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rst_push%0d", i), 32'(push_v[i]), 0);
        chk($sformatf("rst_data%0d", i), 32'(data_v[i]), 0);
        chk($sformatf("rst_abort%0d", i), 32'(ab_v[i]), 0);
        chk($sformatf("rst_cnt%0d", i), 32'({dc[i], ac[i]}), 0);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push_v[i]) begin
          int idx;
          idx = -1;
          obs_n[i]++;
          obs_data[i]  = data_v[i];
          obs_first[i] = first_v[i];
          if (i == 0) a_log.push_back({first_v[0], data_v[0][7:0]});
          for (int k = 0; k < pq.size(); k++)
            if (pq[k].dut == i) begin
              idx = k;
              break;
            end
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL push%0d: got unexpected word %0h expected none",
                     i, data_v[i]);
          end else begin
            chk($sformatf("push_data%0d", i), 32'(data_v[i]),
                32'(pq[idx].data));
            chk($sformatf("push_first%0d", i), 32'(first_v[i]),
                32'(pq[idx].first));
            chk($sformatf("push_cycle%0d", i), cyc, pq[idx].cyc);
            pq.delete(idx);
          end
        end else begin
          chk($sformatf("idle_zero%0d", i), 32'({first_v[i], data_v[i]}), 0);
          for (int k = 0; k < pq.size(); k++)
            if (pq[k].dut == i) begin
              if (pq[k].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL push%0d: got no push expected %0h at cycle %0d",
                         i, pq[k].data, pq[k].cyc);
                pq.delete(k);
              end
              break;
            end
        end
        if (ab_v[i]) begin
          int idx;
          idx = -1;
          obs_ab[i]++;
          for (int k = 0; k < aq.size(); k++)
            if (aq[k].dut == i) begin
              idx = k;
              break;
            end
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL abort%0d: got unexpected pulse expected none", i);
          end else begin
            chk($sformatf("abort_cycle%0d", i), cyc, aq[idx].cyc);
            aq.delete(idx);
          end
        end else begin
          for (int k = 0; k < aq.size(); k++)
            if (aq[k].dut == i) begin
              if (aq[k].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL abort%0d: got no pulse expected one at cycle %0d",
                         i, aq[k].cyc);
                aq.delete(k);
              end
              break;
            end
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic [3:0] d, input logic f);
    spi_clk = c;
    dat     = d;
    full    = f;
    model_step();
  endtask

  task automatic spi_edge(input logic [3:0] d, input logic f);
    drive(1'b0, d, f);
    wait_clk(HALF);
    drive(1'b1, d, f);
    wait_clk(HALF);
    drive(1'b0, d, f);
  endtask

  task automatic set_cs2(input logic a, input logic d);
    wait_clk(HALF);
    cs_a = a;
    cs_d = d;
    model_step();
    wait_clk(HALF);
  endtask

  task automatic set_cs(input logic on);
    set_cs2(on, !on);
  endtask

  task automatic send_a_byte(input logic [7:0] b, input logic f);
    for (int i = 7; i >= 0; i--) begin
      logic [3:0] d;
      d    = 4'($urandom);
      d[0] = b[i];
      spi_edge(d, f);
    end
  endtask

  task automatic check_counts(input string nm);
    wait_clk(12);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_drops%0d", nm, i), 32'(dc[i]), 32'(m_drops[i]));
      chk($sformatf("%s_aborts%0d", nm, i), 32'(ac[i]), 32'(m_aborts[i]));
    end
  endtask

  initial begin
    int n0;
    int n3;
    rst     = 1'b1;
    spi_clk = 1'b0;
    cs_a    = 1'b0;
    cs_d    = 1'b1;
    dat     = 4'h0;
    full    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      obs_n[i]  = 0;
      obs_ab[i] = 0;
    end
    model_reset();
    wait_clk(5);
    chk("reset_push_a", 32'(if_a.command_push), 0);
    chk("reset_drop_a", 32'(dc[0]), 0);
    rst = 1'b0;
    wait_clk(5);

    // single byte
    n0 = obs_n[0];
    set_cs(1'b1);
    send_a_byte(8'h01, 1'b0);
    set_cs(1'b0);
    check_counts("t1");
    chk("t1_count", obs_n[0] - n0, 1);
    chk("t1_data", 32'(obs_data[0]), 32'h01);
    chk("t1_first", 32'(obs_first[0]), 1);
    chk("t1_abort", 32'(obs_ab[0]), 0);

    // two words in one frame
    a_log.delete();
    set_cs(1'b1);
    send_a_byte(8'h23, 1'b0);
    send_a_byte(8'h45, 1'b0);
    set_cs(1'b0);
    check_counts("t2");
    chk("t2_n", a_log.size(), 2);
    if (a_log.size() == 2) begin
      chk("t2_w0", 32'(a_log[0]), 32'h123);
      chk("t2_w1", 32'(a_log[1]), 32'h045);
    end

    // backpressure drop of the third word
    a_log.delete();
    set_cs(1'b1);
    send_a_byte(8'h67, 1'b0);
    send_a_byte(8'h89, 1'b0);
    send_a_byte(8'hAB, 1'b1);
    send_a_byte(8'hCD, 1'b0);
    send_a_byte(8'hEF, 1'b0);
    set_cs(1'b0);
    check_counts("t3");
    chk("t3_drop_a", 32'(dc[0]), 1);
    chk("t3_n", a_log.size(), 4);
    if (a_log.size() == 4) begin
      chk("t3_w0", 32'(a_log[0]), 32'h167);
      chk("t3_w1", 32'(a_log[1]), 32'h089);
      chk("t3_w2", 32'(a_log[2]), 32'h0CD);
      chk("t3_w3", 32'(a_log[3]), 32'h0EF);
    end

    // partial word abort, then a clean frame
    a_log.delete();
    set_cs(1'b1);
    for (int i = 0; i < 5; i++) spi_edge(4'hF, 1'b0);
    set_cs(1'b0);
    check_counts("t4a");
    chk("t4_abort_cnt", 32'(ac[0]), 1);
    chk("t4_abort_pulse", obs_ab[0], 1);
    chk("t4_nopush", a_log.size(), 0);
    set_cs(1'b1);
    send_a_byte(8'h5A, 1'b0);
    set_cs(1'b0);
    check_counts("t4b");
    chk("t4_n", a_log.size(), 1);
    if (a_log.size() == 1) chk("t4_w0", 32'(a_log[0]), 32'h15A);

    // wide lanes
    n0 = obs_n[1];
    set_cs(1'b1);
    for (int i = 0; i < 4; i++) spi_edge(4'b1010, 1'b0);
    set_cs(1'b0);
    check_counts("t5a");
    chk("t5_b_n", obs_n[1] - n0, 1);
    chk("t5_b_data", 32'(obs_data[1]), 32'hAA);
    chk("t5_c_data", 32'(obs_data[2]), 32'hAAAA);
    set_cs(1'b1);
    for (int i = 1; i <= 4; i++) spi_edge(4'(i), 1'b0);
    set_cs(1'b0);
    check_counts("t5b");
    chk("t5_c_word", 32'(obs_data[2]), 32'h1234);
    chk("t5_c_first", 32'(obs_first[2]), 1);

    // active-low CS held at 1 deselects u_d
    n3 = obs_n[3];
    set_cs2(1'b1, 1'b1);
    send_a_byte(8'hC3, 1'b0);
    set_cs2(1'b0, 1'b1);
    check_counts("t6a");
    chk("t6_d_nopush", obs_n[3] - n3, 0);
    chk("t6_a_data", 32'(obs_data[0]), 32'hC3);

    // reset in the middle of a word
    n0 = obs_n[0];
    set_cs(1'b1);
    for (int i = 0; i < 4; i++) spi_edge(4'($urandom), 1'b0);
    rst     = 1'b1;
    cs_a    = 1'b0;
    cs_d    = 1'b1;
    spi_clk = 1'b0;
    model_reset();
    wait_clk(3);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t6_rst_cnt%0d", i), 32'({dc[i], ac[i]}), 0);
    rst = 1'b0;
    wait_clk(10);
    chk("t6_rst_nopush", obs_n[0] - n0, 0);
    chk("t6_rst_abort", 32'(ac[0]), 0);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      int ne;
      ne = ($urandom_range(0, 2) == 0) ? 8 * $urandom_range(1, 3)
                                       : $urandom_range(1, 24);
      set_cs(1'b1);
      for (int e = 0; e < ne; e++)
        spi_edge(4'($urandom), $urandom_range(0, 3) == 0);
      set_cs(1'b0);
    end
    check_counts("rand");
    chk("final_push_queue", pq.size(), 0);
    chk("final_abort_queue", aq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
